// File: rtl/random_roller.sv
// random_roller
//
// Pseudo-random 4-bit dice roller. A start pulse begins a roll. The displayed
// value then changes STEPS times, and each gap is one BASE_PERIOD longer than
// the one before it, so the die appears to slow down before it settles. A
// free-running LFSR supplies the values, which makes the settled value depend
// on the moment of the key press.
//
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_start        one-cycle start pulse; starts a roll or restarts one
//   i_stop         one-cycle pulse; ends a roll at once with a final update
//   o_random_out   displayed value 0..15 (registered)
//   o_rolling      high while a roll is in progress (registered state)
//   o_done         one-cycle pulse in the cycle after the final value is written
//   o_dbg_state    current FSM state (0 = IDLE, 1 = ROLL), for observation only
//
// Handshake: i_start and i_stop are single-cycle strobes. There is no ready
// signal, and a strobe is acted on in the cycle it is high. If both are high
// on the same edge, i_start wins.

module random_roller #(
    parameter int BASE_PERIOD = 2_500_000,
    parameter int STEPS       = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_stop,
    output logic [3:0] o_random_out,
    output logic       o_rolling,
    output logic       o_done,
    output logic       o_dbg_state
);

    // The counter never exceeds BASE_PERIOD*STEPS-1. Keep it at least 1 bit
    // wide so the degenerate BASE_PERIOD=STEPS=1 case still elaborates.
    localparam int CNT_W  = (BASE_PERIOD * STEPS > 1) ? $clog2(BASE_PERIOD * STEPS) : 1;
    localparam int STEP_W = $clog2(STEPS + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ROLL = 1'b1;

    // BASE_PERIOD can equal 2^CNT_W when STEPS=1, which truncates it to 0.
    // The interval limit is still correct, because it is computed modulo
    // 2^CNT_W.
    localparam logic [CNT_W-1:0]  BASE_C    = CNT_W'(BASE_PERIOD);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [3:0]        out_q, out_d;
    logic              done_q, done_d;

    logic [3:0]        cand;
    logic [3:0]        upd_val;
    logic [CNT_W-1:0]  limit;
    logic              expired;

    always_comb begin
        // The LFSR is x^16+x^14+x^13+x^11. It runs in every state and is
        // reseeded only by reset.
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        // An update must always change the display. On a collision, step the
        // candidate up by one; the 4-bit add wraps 15 to 0.
        cand    = lfsr_q[3:0];
        upd_val = (cand == out_q) ? cand + 4'd1 : cand;

        // Interval k is BASE_PERIOD*(k+1) cycles long. cnt counts 0..len-1.
        limit   = BASE_C * (CNT_W'(step_q) + CNT_W'(1)) - CNT_W'(1);
        expired = (cnt_q == limit);

        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        out_d   = out_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // i_stop has no effect here. The display holds its value.
                if (i_start) begin
                    state_d = S_ROLL;
                    cnt_d   = '0;
                    step_d  = '0;
                end
            end
            S_ROLL: begin
                if (i_start) begin
                    // A restart suppresses any update or done on this edge.
                    cnt_d  = '0;
                    step_d = '0;
                end else if (i_stop) begin
                    out_d   = upd_val;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    step_d  = '0;
                end else if (expired) begin
                    out_d = upd_val;
                    cnt_d = '0;
                    if (step_q == STEP_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            step_q  <= '0;
            lfsr_q  <= LFSR_SEED;
            out_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            lfsr_q  <= lfsr_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign o_random_out = out_q;
    assign o_rolling    = (state_q == S_ROLL);
    assign o_done       = done_q;
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_random_roller.sv
// Testbench for random_roller with BASE_PERIOD=4 and STEPS=3.
// A table of per-cycle vectors drives the long schedules. Hand-written
// sequences cover reset, the wrap/collision case and reset during a roll.

module tb_random_roller;

    localparam int BASE  = 4;
    localparam int STEPS = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] o_random_out;
    logic       o_rolling;
    logic       o_done;
    logic       o_dbg_state;

    random_roller #(.BASE_PERIOD(BASE), .STEPS(STEPS)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_stop       (stop),
        .o_random_out (o_random_out),
        .o_rolling    (o_rolling),
        .o_done       (o_done),
        .o_dbg_state  (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Reference LFSR. It follows the reset and the clock on its own.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Runs one clock cycle with the given strobes, then checks the outputs
    // 1 time unit after the edge. If upd is set, this edge must write a
    // new value taken from the reference LFSR.
    task automatic run_cycle(input logic s, input logic p, input logic upd,
                             input logic roll, input logic done);
        logic [3:0] cand;
        logic [3:0] prev;
        logic [3:0] nv;
        @(negedge clk);
        start = s;
        stop  = p;
        cand  = m_lfsr[3:0];
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        prev  = exp_q[$];
        if (upd) begin
            nv = (cand == prev) ? cand + 4'd1 : cand;
            exp_q.push_back(nv);
            chk("changed", int'(o_random_out != prev), 1);
        end
        chk("out", o_random_out, exp_q[$]);
        chk("rolling", o_rolling, roll);
        chk("state", o_dbg_state, roll);
        chk("done", o_done, done);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic start;
        logic stop;
        logic upd;
        logic rolling;
        logic done;
        int   n;
    } vec_t;

    vec_t vecs[$];
    int   roll_start;
    int   roll_end;

    task automatic add(input logic s, input logic p, input logic u,
                       input logic r, input logic d, input int n);
        vec_t v;
        v.start = s; v.stop = p; v.upd = u; v.rolling = r; v.done = d; v.n = n;
        vecs.push_back(v);
    endtask

    task automatic apply(input int from, input int to);
        for (int i = from; i < to; i++)
            for (int r = 0; r < vecs[i].n; r++)
                run_cycle(vecs[i].start, vecs[i].stop, vecs[i].upd,
                          vecs[i].rolling, vecs[i].done);
    endtask

    // Wait in IDLE until the LFSR nibble at the next-but-one edge is 15.
    // Then start, and stop on the following edge so the stop samples 15.
    task automatic seek_and_stop();
        logic [15:0] nx;
        logic        hit;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            nx = lfsr_step(m_lfsr);
            if (nx[3:0] == 4'd15) begin
                run_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
                run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
                hit = 1'b1;
            end else begin
                run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
        chk("seek_bound", hit, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test ----------------
    initial begin
        // Idle after reset: the value must hold with no start.
        add(0, 0, 0, 0, 0, 5);
        // Full roll: updates at t+4, t+12, t+24, then a 100-cycle hold.
        roll_start = vecs.size();
        add(1, 0, 0, 1, 0, 1);
        add(0, 0, 0, 1, 0, 3);  add(0, 0, 1, 1, 0, 1);
        add(0, 0, 0, 1, 0, 7);  add(0, 0, 1, 1, 0, 1);
        add(0, 0, 0, 1, 0, 11); add(0, 0, 1, 0, 1, 1);
        roll_end = vecs.size();
        add(0, 0, 0, 0, 0, 100);
        // Restart at t+10: nothing at t+12; updates at t+14, t+22, t+34.
        add(1, 0, 0, 1, 0, 1);
        add(0, 0, 0, 1, 0, 3);  add(0, 0, 1, 1, 0, 1);
        add(0, 0, 0, 1, 0, 5);  add(1, 0, 0, 1, 0, 1);
        add(0, 0, 0, 1, 0, 3);  add(0, 0, 1, 1, 0, 1);
        add(0, 0, 0, 1, 0, 7);  add(0, 0, 1, 1, 0, 1);
        add(0, 0, 0, 1, 0, 11); add(0, 0, 1, 0, 1, 1);
        add(0, 0, 0, 0, 0, 3);
        // Stop at t+6 after the t+4 update; then stop while IDLE is ignored.
        add(1, 0, 0, 1, 0, 1);
        add(0, 0, 0, 1, 0, 3);  add(0, 0, 1, 1, 0, 1);
        add(0, 0, 0, 1, 0, 1);  add(0, 1, 1, 0, 1, 1);
        add(0, 0, 0, 0, 0, 5);  add(0, 1, 0, 0, 0, 2);
        add(0, 0, 0, 0, 0, 2);
        // Start+stop at an interval end: restart only, so updates come at
        // t+8, t+16, t+28.
        add(1, 0, 0, 1, 0, 1);
        add(0, 0, 0, 1, 0, 3);  add(1, 1, 0, 1, 0, 1);
        add(0, 0, 0, 1, 0, 3);  add(0, 0, 1, 1, 0, 1);
        add(0, 0, 0, 1, 0, 7);  add(0, 0, 1, 1, 0, 1);
        add(0, 0, 0, 1, 0, 11); add(0, 0, 1, 0, 1, 1);
        // A new start+stop in the cycle where done is high begins another
        // roll at once.
        add(1, 1, 0, 1, 0, 1);
        add(0, 0, 0, 1, 0, 3);  add(0, 0, 1, 1, 0, 1);
        add(0, 0, 0, 1, 0, 7);  add(0, 0, 1, 1, 0, 1);
        add(0, 0, 0, 1, 0, 11); add(0, 0, 1, 0, 1, 1);
        add(0, 0, 0, 0, 0, 3);

        // 1. Reset asserted asynchronously in the middle of a cycle.
        #7;
        rst_n = 1'b0;
        #1;
        chk("rst_async_out", o_random_out, 0);
        chk("rst_async_rolling", o_rolling, 0);
        chk("rst_async_done", o_done, 0);
        exp_q.push_back(4'd0);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("rst_hold_out", o_random_out, 0);
            chk("rst_hold_done", o_done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 2-5. Table-driven schedules.
        apply(0, vecs.size());

        // 5. Wrap: bring the display to 15, then force a collision at 15.
        for (int a = 0; a < 3 && exp_q[$] != 4'd15; a++) seek_and_stop();
        chk("reach15", o_random_out, 15);
        seek_and_stop();
        chk("wrap15to0", o_random_out, 0);

        // 6. Reset asserted mid-roll at t+8.
        run_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (4) run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midroll_rst_out", o_random_out, 0);
        chk("midroll_rst_rolling", o_rolling, 0);
        chk("midroll_rst_done", o_done, 0);
        exp_q.push_back(4'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("midroll_hold_done", o_done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // The roller must wait for a start. The LFSR restarts from its seed,
        // so the replayed roll must match the freshly reset reference.
        repeat (6) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(roll_start, roll_end);
        repeat (3) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/random_roller.md
# random_roller

Pseudo-random 4-bit roller for the lab1 dice datapath. It sits between the debounced KEY[0] press pulse and the two-digit seven-segment decoder. On a start pulse it updates its 4-bit output with progressively longer gaps between updates, like a die slowing down, and then holds the final value. A free-running LFSR provides entropy, so the settled value depends on when the user presses the key.

## Interface

- BASE_PERIOD, default 2_500_000: cycles of the first update interval (50 ms at 50 MHz); must be ≥ 1.
- STEPS, default 16: number of updates per roll, including the final one; must be ≥ 1.

Ports:

- i_clk  in  1  system clock (CLOCK_50).
- i_rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- i_start  in  1  one-cycle start pulse from the debouncer.
- i_stop  in  1  one-cycle pulse; forces an immediate final value.
- o_random_out  out  4  displayed value, 0..15, fed to the hex decoder.
- o_rolling  out  1  high while a roll is in progress.
- o_done  out  1  one-cycle pulse when the final value is written.

## Operation

- Reset values:
  - o_random_out = 0, o_rolling = 0, o_done = 0.
  - State = IDLE; step = 0; interval counter cnt = 0.
  - lfsr = 16'hACE1.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11.
  - Advances every cycle in every state: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - Never reseeded except by reset.
- Update rule:
  - The candidate value v is lfsr[3:0], taken from the LFSR register before that edge's advance.
  - If v equals the current o_random_out, write (v+1) mod 16 instead; 15 wraps to 0.
  - The displayed value therefore always changes on an update.
- State IDLE:
  - o_random_out is held.
  - i_start → ROLL; cnt = 0, step = 0.
  - i_stop is ignored.
- State ROLL:
  - cnt increments each cycle.
  - When cnt == BASE_PERIOD*(step+1)-1:
    - apply the update rule;
    - cnt = 0;
    - if step == STEPS-1: → IDLE and pulse o_done;
    - otherwise step = step+1.
  - i_stop (without i_start): apply the update rule on that edge, → IDLE, pulse o_done.
  - i_start: restart with cnt = 0, step = 0, and stay in ROLL. No update and no o_done on that edge, even if it coincides with an interval end or with i_stop.
- Priority on the same edge: reset > i_start > i_stop > interval expiry.
- Widths:
  - cnt is $clog2(BASE_PERIOD*STEPS) bits.
  - step is $clog2(STEPS+1) bits.
  - Interval products are computed at that width, with no overflow for legal parameters.
- Reset asserted mid-roll: every register returns to its reset value immediately, with no o_done.

## Timing

- Every output is registered; there is no combinational path from input to output.
- i_start is sampled at edge t. o_rolling is high from edge t until the edge that writes the final value, where it goes low.
- Update k (k = 0..STEPS-1) appears at edge t + BASE_PERIOD*(k+1)(k+2)/2.
- The final update is at t + BASE_PERIOD*STEPS*(STEPS+1)/2. o_done is high for exactly one cycle, in the cycle following that edge.
- i_stop is sampled at edge s. The final value and o_done appear at edge s, and o_rolling goes low at edge s.
- A roll has no minimum spacing: i_start in the same cycle that o_done goes high begins a new roll.

## Test plan

Use BASE_PERIOD=4, STEPS=3, and a bench reference model of the LFSR and the update rule.

1. **Reset.** Assert i_rst_n=0 asynchronously mid-cycle → all outputs read 0 within the same cycle. Hold reset for 5 cycles, then release → o_random_out stays 0 with no start.
2. **Full roll.** Pulse i_start at edge t → o_rolling=1 from t. Updates at t+4, t+12, t+24, each matching the model and each differing from the prior value. o_done is high for exactly one cycle after t+24; o_rolling=0 at t+24. The output is held for a further 100 cycles.
3. **Restart.** Pulse i_start at t, then again at t+10 → no update at t+12. Updates follow at t+14, t+22, t+34.
4. **Stop.** Pulse i_start at t, then i_stop at t+6 → one update at t+6 (after the t+4 update), o_done after t+6, o_rolling=0. No further updates. Also assert i_stop in IDLE → no change.
5. **Wrap and collision.** Force the model case where lfsr[3:0] equals the current o_random_out = 15 → the output becomes 0. Pulse i_start and i_stop on the same edge → restart only, no o_done.
6. **Reset mid-roll.** Assert reset at t+8 → outputs return to 0, no o_done. After release, i_start is needed to roll again, and the LFSR sequence restarts from 16'hACE1.
